// File: rtl/vector_driver.sv
// rtl/vector_driver.sv - stimulus FIFO consumer: applies vectors to a target, captures responses into the result FIFO
// Optional VECTOR_DRIVER_SYNC_EN: dut_out passes a 2-flop synchronizer and sampling waits 2 extra cycles.
module vector_driver #(
    parameter int STF_WIDTH   = 24,
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    output logic                             sfifo_rdreq,
    input  logic                             sfifo_rdempty,
    input  logic [STF_WIDTH+CYCLE_RANGE:0]   sfifo_dataq,
    output logic [RTF_WIDTH-1:0]             rfifo_data,
    output logic                             rfifo_wrreq,
    input  logic                             rfifo_wrfull,
    output logic [STF_WIDTH-1:0]             dut_in,
    input  logic [RTF_WIDTH-1:0]             dut_out,
    output logic                             dut_clock,
    output logic                             idle,
    output logic [15:0]                      vec_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_CLK_HI, S_CLK_LO, S_WRITE
    } state_t;

    state_t                  state;
    logic [CYCLE_RANGE-1:0]  cnt;
    logic [1:0]              settle;
    logic [RTF_WIDTH-1:0]    sample_data;

`ifdef VECTOR_DRIVER_SYNC_EN
    localparam logic [1:0] SETTLE_CYCLES = 2'd2;
    logic [RTF_WIDTH-1:0] sync_q1, sync_q2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= dut_out;
            sync_q2 <= sync_q1;
        end
    end
    assign sample_data = sync_q2;
`else
    localparam logic [1:0] SETTLE_CYCLES = 2'd0;
    assign sample_data = dut_out;
`endif

    assign sfifo_rdreq = (state == S_FETCH);
    // Full gates the write strobe directly so a stalled result is never pushed.
    assign rfifo_wrreq = (state == S_WRITE) && !rfifo_wrfull;
    assign idle        = (state == S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            settle     <= '0;
            rfifo_data <= '0;
            dut_in     <= '0;
            dut_clock  <= 1'b0;
            vec_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && !sfifo_rdempty)
                        state <= S_FETCH;
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    dut_in <= sfifo_dataq[STF_WIDTH-1:0];
                    cnt    <= sfifo_dataq[STF_WIDTH+CYCLE_RANGE-1:STF_WIDTH];
                    settle <= '0;
                    state  <= sfifo_dataq[STF_WIDTH+CYCLE_RANGE] ? S_CLK_HI : S_HOLD;
                end
                S_HOLD: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (settle != SETTLE_CYCLES)
                        settle <= settle + 2'd1;
                    else begin
                        rfifo_data <= sample_data;
                        state      <= S_WRITE;
                    end
                end
                S_CLK_HI: begin
                    dut_clock <= 1'b1;
                    state     <= S_CLK_LO;
                end
                S_CLK_LO: begin
                    // The target's rising edge lands at the start of this cycle, so its response is sampled at the end.
                    dut_clock <= 1'b0;
                    if (cnt != '0) begin
                        cnt   <= cnt - 1'b1;
                        state <= S_CLK_HI;
                    end else if (settle != SETTLE_CYCLES)
                        settle <= settle + 2'd1;
                    else begin
                        rfifo_data <= sample_data;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!rfifo_wrfull) begin
                        vec_count <= vec_count + 16'd1;
                        state     <= (enable && !sfifo_rdempty) ? S_FETCH : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_driver.sv
// tb/tb_vector_driver.sv - scoreboard bench for vector_driver with a stimulus FIFO model and target models
module tb_vector_driver;

    localparam int STF = 24;
    localparam int RTF = 24;
    localparam int CR  = 5;
`ifdef VECTOR_DRIVER_SYNC_EN
    localparam int XTRA = 2;
`else
    localparam int XTRA = 0;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               sfifo_rdreq;
    logic               sfifo_rdempty;
    logic [STF+CR:0]    sfifo_dataq = '0;
    logic [RTF-1:0]     rfifo_data;
    logic               rfifo_wrreq;
    logic               rfifo_wrfull;
    logic [STF-1:0]     dut_in;
    logic [RTF-1:0]     dut_out;
    logic               dut_clock;
    logic               idle;
    logic [15:0]        vec_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [STF+CR:0]    sf_mem [0:15];
    int                 sf_wr = 0;
    int                 sf_rd = 0;
    logic [RTF-1:0]     exp_q [$];
    logic               dut_sel;
    logic [RTF-1:0]     tgt_cnt = '0;

    vector_driver #(.STF_WIDTH(STF), .RTF_WIDTH(RTF), .CYCLE_RANGE(CR)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .sfifo_rdreq(sfifo_rdreq), .sfifo_rdempty(sfifo_rdempty), .sfifo_dataq(sfifo_dataq),
        .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
        .dut_in(dut_in), .dut_out(dut_out), .dut_clock(dut_clock),
        .idle(idle), .vec_count(vec_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stimulus FIFO: show-ahead off, data valid the cycle after the read request.
    assign sfifo_rdempty = (sf_wr == sf_rd);
    always @(posedge clock) begin
        if (sfifo_rdreq) begin
            sfifo_dataq <= sf_mem[sf_rd & 15];
            sf_rd       <= sf_rd + 1;
        end
    end

    // Targets: an inverter, or a counter clocked by dut_clock.
    always @(posedge dut_clock) tgt_cnt <= tgt_cnt + 1'b1;
    assign dut_out = dut_sel ? tgt_cnt : ~dut_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (sfifo_rdreq)
                check("rdreq_not_empty", {31'd0, sfifo_rdempty}, 32'd0);
            if (rfifo_wrreq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h expected=none", rfifo_data);
                end else begin
                    check("rfifo_data", rfifo_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_word(input logic mode, input logic [CR-1:0] n, input logic [STF-1:0] vec);
        sf_mem[sf_wr & 15] = {mode, n, vec};
        sf_wr = sf_wr + 1;
    endtask

    task automatic wait_rdreq(output int t);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clock);
            if (sfifo_rdreq) break;
        end
        if (k == 300) begin
            checks++; errors++;
            $display("FAIL rdreq_timeout actual=none expected=rdreq");
        end
        t = cyc;
    endtask

    task automatic wait_wr(output int t);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clock);
            if (rfifo_wrreq) break;
        end
        if (k == 300) begin
            checks++; errors++;
            $display("FAIL wrreq_timeout actual=none expected=wrreq");
        end
        t = cyc;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && idle) break;
        end
        if (k == 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        int t, w;
        reset_n = 1'b0;
        enable = 1'b1;
        rfifo_wrfull = 1'b0;
        dut_sel = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_rdreq", {31'd0, sfifo_rdreq}, 0);
        check("rst_wrreq", {31'd0, rfifo_wrreq}, 0);
        check("rst_rfifo_data", rfifo_data, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_dut_clock", {31'd0, dut_clock}, 0);
        check("rst_idle", {31'd0, idle}, 1);
        check("rst_vec_count", vec_count, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Mode 0, N=3, inverting target
        push_word(1'b0, 5'd3, 24'h00A5A5);
        exp_q.push_back(24'hFF5A5A);
        wait_rdreq(t);
        @(negedge clock);
        check("dut_in_t1", dut_in, 24'h000000);
        @(negedge clock);
        check("dut_in_t2", dut_in, 24'h00A5A5);
        wait_wr(w);
        check("mode0_latency", w - t, 3 + 3 + XTRA);
        @(negedge clock);
        check("vec_count_1", vec_count, 1);
        check("dut_in_retained", dut_in, 24'h00A5A5);

        // Mode 1, N=2, counter target clocked by dut_clock
        dut_sel = 1'b1;
        push_word(1'b1, 5'd2, 24'h000777);
        exp_q.push_back(24'd3);
        wait_rdreq(t);
        wait_wr(w);
        check("mode1_latency", w - t, 4 + 4 + XTRA);
        check("mode1_pulses", tgt_cnt, 3);
        @(negedge clock);
        check("dut_clock_low", {31'd0, dut_clock}, 0);
        check("vec_count_2", vec_count, 2);
        dut_sel = 1'b0;

        // Three back-to-back N=0 words, result FIFO full across the second write
        push_word(1'b0, 5'd0, 24'h000001);
        push_word(1'b0, 5'd0, 24'h123456);
        push_word(1'b0, 5'd0, 24'hABCDEF);
        exp_q.push_back(24'hFFFFFE);
        exp_q.push_back(24'hEDCBA9);
        exp_q.push_back(24'h543210);
        wait_wr(w);
        @(posedge clock);
        #1 rfifo_wrfull = 1'b1;
        for (int i = 0; i < 8 + XTRA; i++) begin
            @(negedge clock);
            check("wrreq_while_full", {31'd0, rfifo_wrreq}, 0);
            if (i >= 3 + XTRA)
                check("stall_data", rfifo_data, 24'hEDCBA9);
        end
        @(posedge clock);
        #1 rfifo_wrfull = 1'b0;
        wait_drain();
        check("vec_count_5", vec_count, 5);
        check("sfifo_drained", sf_wr - sf_rd, 0);

        // enable dropped during HOLD of the first of two queued words
        push_word(1'b0, 5'd5, 24'h0F0F0F);
        push_word(1'b0, 5'd5, 24'h333333);
        exp_q.push_back(24'hF0F0F0);
        wait_rdreq(t);
        repeat (3) @(negedge clock);
        enable = 1'b0;
        wait_wr(w);
        repeat (10) @(negedge clock);
        check("en_drop_idle", {31'd0, idle}, 1);
        check("en_drop_left", sf_wr - sf_rd, 1);
        check("vec_count_6", vec_count, 6);
        exp_q.push_back(24'hCCCCCC);
        enable = 1'b1;
        wait_drain();
        check("vec_count_7", vec_count, 7);

        // Reset during CLK_HI drops the vector
        dut_sel = 1'b1;
        push_word(1'b1, 5'd4, 24'h0000AA);
        wait_rdreq(t);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mrst_rdreq", {31'd0, sfifo_rdreq}, 0);
        check("mrst_wrreq", {31'd0, rfifo_wrreq}, 0);
        check("mrst_rfifo_data", rfifo_data, 0);
        check("mrst_dut_in", dut_in, 0);
        check("mrst_dut_clock", {31'd0, dut_clock}, 0);
        check("mrst_idle", {31'd0, idle}, 1);
        check("mrst_vec_count", vec_count, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        check("post_rst_idle", {31'd0, idle}, 1);
        check("post_rst_vec_count", vec_count, 0);
        dut_sel = 1'b0;

        // vec_count wrap: preset near the top while idle, then two N=0 vectors
        force dut.vec_count = 16'hFFFE;
        @(posedge clock);
        #1 release dut.vec_count;
        push_word(1'b0, 5'd0, 24'h000000);
        push_word(1'b0, 5'd0, 24'hFFFFFF);
        exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'h000000);
        wait_drain();
        check("vec_count_wrap", vec_count, 0);

        // Long idle with an empty stimulus FIFO; monitor flags any read request
        repeat (50) @(negedge clock);
        check("final_idle", {31'd0, idle}, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
